fp_divide: RTL and testbench

FP_DIVIDE -- requirements
Module: fp_divide

---
 rtl/fp_pkg.sv | 28 ++
 rtl/fp_div_core.sv | 70 +++++++
 rtl/fp_divide.sv | 140 ++++++++++++++
 tb/tb_fp_divide.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared float32 constants and types for the fp arithmetic blocks.
// Latency: n/a (package).
// Backpressure: n/a (package).
package fp_pkg;

    localparam int EXP_W     = 8;
    localparam int FRAC_W    = 23;
    localparam int MANT_W    = FRAC_W + 1;   // mantissa with hidden one
    localparam int QUOT_W    = MANT_W + 1;   // quotient bits produced per divide
    localparam int DIV_ITERS = QUOT_W;       // one quotient bit per iteration
    localparam int EXP_BIAS  = 127;

    localparam logic [31:0] POS_INF    = 32'h7F80_0000;
    localparam logic [31:0] MAX_FINITE = 32'h7F7F_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    // Denormals are flushed: a zero exponent field means the operand is zero.
    function automatic logic is_zero(input logic [EXP_W-1:0] exp_field);
        return (exp_field == '0);
    endfunction

endpackage

// File: rtl/fp_div_core.sv
// Restoring mantissa divider: one quotient bit per step, MSB first.
// Latency: DIV_ITERS steps after load; last flags the final step.
// Backpressure: none; the caller gates progress with step.
module fp_div_core
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [MANT_W-1:0] ma,
    input  logic [MANT_W-1:0] mb,
    output logic [QUOT_W-1:0] quot,
    output logic              last
);

    logic [QUOT_W-1:0] rem_q,  rem_d;
    logic [QUOT_W-1:0] quot_q, quot_d;
    logic [MANT_W-1:0] mb_q,   mb_d;
    logic [4:0]        cnt_q,  cnt_d;
    logic [QUOT_W-1:0] mb_ext;

    // Iteration state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quot_q <= '0;
            mb_q   <= '0;
            cnt_q  <= '0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            mb_q   <= mb_d;
            cnt_q  <= cnt_d;
        end
    end

    // Load operands or perform one compare/subtract/shift step.
    // The remainder always stays below 2*mb, so after the subtract or skip it
    // is below mb (< 2^24) and the left shift never loses a set bit.
    always_comb begin
        rem_d  = rem_q;
        quot_d = quot_q;
        mb_d   = mb_q;
        cnt_d  = cnt_q;
        mb_ext = {1'b0, mb_q};
        if (load) begin
            rem_d  = {1'b0, ma};
            quot_d = '0;
            mb_d   = mb;
            cnt_d  = '0;
        end else if (step) begin
            if (rem_q >= mb_ext) begin
                rem_d  = (rem_q - mb_ext) << 1;
                quot_d = {quot_q[QUOT_W-2:0], 1'b1};
            end else begin
                rem_d  = rem_q << 1;
                quot_d = {quot_q[QUOT_W-2:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
        end
    end

    // Outputs: quotient register and final-step indication.
    always_comb begin
        quot = quot_q;
        last = step && (cnt_q == 5'(DIV_ITERS - 1));
    end

endmodule

// File: rtl/fp_divide.sv
// Float32 divider (non-negative magnitudes, truncating, denormals flushed).
// Latency: fixed 27 cycles from accepted start to the done pulse.
// Backpressure: start is ignored while an operation is in flight; no queuing.
module fp_divide
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        div_zero
);

    div_state_e        state_q, state_d;
    logic [EXP_W-1:0]  ea_q, ea_d;
    logic [EXP_W-1:0]  eb_q, eb_d;
    logic              a_zero_q, a_zero_d;
    logic              b_zero_q, b_zero_d;
    logic [31:0]       result_q, result_d;
    logic              div_zero_q, div_zero_d;

    logic              load;
    logic              step;
    logic              last;
    logic [QUOT_W-1:0] quot;
    logic signed [9:0] exp_s;
    logic [FRAC_W-1:0] frac;
    logic [31:0]       norm_res;
    logic              norm_dz;

    // Operand signs carry no meaning for these magnitudes.
    logic              sign_unused;
    assign sign_unused = a[31] ^ b[31];

    fp_div_core u_core (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .ma   ({1'b1, a[FRAC_W-1:0]}),
        .mb   ({1'b1, b[FRAC_W-1:0]}),
        .quot (quot),
        .last (last)
    );

    // State and captured-operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ea_q       <= '0;
            eb_q       <= '0;
            a_zero_q   <= 1'b0;
            b_zero_q   <= 1'b0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ea_q       <= ea_d;
            eb_q       <= eb_d;
            a_zero_q   <= a_zero_d;
            b_zero_q   <= b_zero_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_CALC;
            ST_CALC: if (last)  state_d = ST_NORM;
            ST_NORM: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and core controls.
    always_comb begin
        load = (state_q == ST_IDLE) && start;
        step = (state_q == ST_CALC);
        busy = (state_q == ST_CALC) || (state_q == ST_NORM);
        done = (state_q == ST_DONE);
    end

    // Capture exponents and zero classes when an operation is accepted.
    always_comb begin
        ea_d     = ea_q;
        eb_d     = eb_q;
        a_zero_d = a_zero_q;
        b_zero_d = b_zero_q;
        if (load) begin
            ea_d     = a[30:23];
            eb_d     = b[30:23];
            a_zero_d = is_zero(a[30:23]);
            b_zero_d = is_zero(b[30:23]);
        end
    end

    // Normalise the quotient, apply range limits and special cases.
    // q[24]=1 means the mantissa ratio is in [1,2); otherwise it is in [0.5,1)
    // and one extra quotient bit is consumed, costing one exponent step.
    always_comb begin
        exp_s = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q})
              + (quot[QUOT_W-1] ? 10'sd127 : 10'sd126);
        frac  = quot[QUOT_W-1] ? quot[FRAC_W:1] : quot[FRAC_W-1:0];
        norm_dz = 1'b0;
        if (b_zero_q) begin
            norm_res = POS_INF;
            norm_dz  = 1'b1;
        end else if (a_zero_q) begin
            norm_res = '0;
        end else if (exp_s <= 10'sd0) begin
            norm_res = '0;
        end else if (exp_s >= 10'sd255) begin
            norm_res = MAX_FINITE;
        end else begin
            norm_res = {1'b0, exp_s[7:0], frac};
        end
    end

    // Result and flag update on the way into DONE, held afterwards.
    always_comb begin
        result_d   = result_q;
        div_zero_d = div_zero_q;
        if (state_q == ST_NORM) begin
            result_d   = norm_res;
            div_zero_d = norm_dz;
        end
    end

    assign result   = result_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_fp_divide.sv
// Self-checking bench for fp_divide: vector table plus handshake/reset sequences.
// Latency: expects done exactly 27 cycles after the start-sampling edge.
// Backpressure: checks that starts during an operation are dropped.
module tb_fp_divide;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_zero;

    int errors = 0;
    int checks = 0;
    int ndone  = 0;

    logic [32:0] exp_q[$];   // {div_zero, result}

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dz;
    } vec_t;

    vec_t vecs[10];

    fp_divide dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a_i),
        .b        (b_i),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard: every done pops one expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            logic [32:0] e;
            ndone++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=done result=%h required=no done", result);
            end else begin
                e = exp_q.pop_front();
                check("result", result, e[31:0]);
                check("div_zero", {31'b0, div_zero}, {31'b0, e[32]});
            end
        end
    end

    // Wait for done after the start edge; checks latency, busy profile and hold.
    task automatic wait_done(input string name, input logic [31:0] er);
        int lat = 0;
        bit busy_ok = 1'b1;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            a_i   = $urandom;
            b_i   = $urandom;
            if (done === 1'b1) begin
                lat = k;
                if (busy !== 1'b0) busy_ok = 1'b0;
            end else if (busy !== 1'b1) begin
                busy_ok = 1'b0;
            end
        end
        check({name, "_latency"}, lat, 27);
        check({name, "_busy"}, {31'b0, busy_ok}, 32'd1);
        @(negedge clk);
        check({name, "_hold"}, result, er);
        check({name, "_pulse"}, {31'b0, done}, 32'd0);
    endtask

    task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic edz);
        @(negedge clk);
        a_i   = a;
        b_i   = b;
        start = 1'b1;
        exp_q.push_back({edz, er});
        wait_done(name, er);
    endtask

    initial begin
        int lat;
        int nd0;

        vecs[0] = '{"six_by_two",  32'h40C00000, 32'h40000000, 32'h40400000, 1'b0};
        vecs[1] = '{"one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0};
        vecs[2] = '{"zero_by_two", 32'h00000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[3] = '{"two_by_zero", 32'h40000000, 32'h00000000, 32'h7F800000, 1'b1};
        vecs[4] = '{"overflow",    32'h7F000000, 32'h00800000, 32'h7F7FFFFF, 1'b0};
        vecs[5] = '{"underflow",   32'h00800000, 32'h7F000000, 32'h00000000, 1'b0};
        vecs[6] = '{"zero_by_zero", 32'h00000000, 32'h00000000, 32'h7F800000, 1'b1};
        vecs[7] = '{"signs_ignored", 32'hC0C00000, 32'hC0000000, 32'h40400000, 1'b0};
        vecs[8] = '{"denorm_divisor", 32'h3F800000, 32'h00000001, 32'h7F800000, 1'b1};
        vecs[9] = '{"two_by_two",  32'h40000000, 32'h40000000, 32'h3F800000, 1'b0};

        // Reset, with start held high to show reset wins.
        rst   = 1'b1;
        start = 1'b1;
        a_i   = 32'h40C00000;
        b_i   = 32'h40000000;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_div_zero", {31'b0, div_zero}, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {31'b0, busy}, 32'd0);

        foreach (vecs[i]) begin
            do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dz);
        end

        // A second start in cycle 5 is dropped; only one done, first result.
        @(negedge clk);
        a_i   = 32'h40C00000;
        b_i   = 32'h40000000;
        start = 1'b1;
        exp_q.push_back({1'b0, 32'h40400000});
        nd0 = ndone;
        lat = 0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            start = (k == 5);
            if (k == 5) begin
                a_i = 32'h3F800000;
                b_i = 32'h40400000;
            end
            if (done === 1'b1 && lat == 0) lat = k;
        end
        check("ignored_start_latency", lat, 27);
        check("ignored_start_done_count", ndone - nd0, 1);

        // Reset in cycle 10 aborts; a start right after completes normally.
        @(negedge clk);
        a_i   = 32'h40000000;
        b_i   = 32'h3F800000;
        start = 1'b1;
        nd0   = ndone;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 10) rst = 1'b1;
        end
        @(negedge clk);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_div_zero", {31'b0, div_zero}, 32'd0);
        check("abort_no_done", ndone - nd0, 0);
        rst   = 1'b0;
        start = 1'b1;
        a_i   = 32'h3F800000;
        b_i   = 32'h40400000;
        exp_q.push_back({1'b0, 32'h3EAAAAAA});
        wait_done("after_reset", 32'h3EAAAAAA);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
